fifo_write_arbiter: RTL and testbench

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

---
 rtl/fifo_ctrl_pkg.sv | 23 ++
 rtl/rr_priority_select.sv | 38 +++
 rtl/fifo_write_arbiter.sv | 127 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// ============================================================================
// Module      : fifo_ctrl_pkg
// Description : Shared default constants and helpers for the FIFO and its
//               write-side controllers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_FIFO_SIZE  = 8;
  localparam int DEF_SIZE_BITS  = 3;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : fifo_ctrl_pkg

`default_nettype wire

// File: rtl/rr_priority_select.sv
// ============================================================================
// Module      : rr_priority_select
// Description : Combinational round-robin selector. The search starts at
//               i_last_winner+1 (mod NUM_REQ) and returns the first active
//               request index together with a valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_select #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_winner,
  output logic [IDX_W-1:0]   o_winner,
  output logic               o_valid
);

  logic [IDX_W-1:0] w_idx;

  // Walk the requesters starting just after the last winner; the first hit wins.
  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    w_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = IDX_W'((int'(i_last_winner) + k) % NUM_REQ);
      if (!o_valid && i_req[w_idx]) begin
        o_winner = w_idx;
        o_valid  = 1'b1;
      end
    end
  end

endmodule : rr_priority_select

`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
// ============================================================================
// Module      : fifo_write_arbiter
// Description : Round-robin write arbiter in front of a FIFO. Accepts one
//               requester word per cycle while the FIFO has space, and
//               tracks occupancy, full/empty and read underflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_write_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int FIFO_SIZE  = DEF_FIFO_SIZE,
  parameter int SIZE_BITS  = DEF_SIZE_BITS
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          fifo_read_enable,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          write_enable,
  output logic [DATA_WIDTH-1:0]         write_data,
  output logic [SIZE_BITS:0]            occupancy,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic                          underflow
);

  localparam int               IDX_W      = idx_width(NUM_REQ);
  localparam logic [SIZE_BITS:0] c_fifo_size = (SIZE_BITS+1)'(FIFO_SIZE);
  localparam logic [SIZE_BITS:0] c_occ_one   = (SIZE_BITS+1)'(1);
  localparam logic [IDX_W-1:0]   c_last_rst  = IDX_W'(NUM_REQ-1);

  logic [NUM_REQ-1:0]    r_grant;
  logic                  r_write_enable;
  logic [DATA_WIDTH-1:0] r_write_data;
  logic [SIZE_BITS:0]    r_occupancy;
  logic                  r_fifo_full;
  logic                  r_fifo_empty;
  logic                  r_underflow;
  logic [IDX_W-1:0]      r_last_winner;

  logic [DATA_WIDTH-1:0] w_req_words [NUM_REQ];
  logic [IDX_W-1:0]      w_winner;
  logic                  w_valid;
  logic                  w_space;
  logic                  w_issue;
  logic                  w_read_ok;
  logic [SIZE_BITS:0]    w_occ_next;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_req_words[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_priority_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .i_req         (req),
    .i_last_winner (r_last_winner),
    .o_winner      (w_winner),
    .o_valid       (w_valid)
  );

  // Space is judged on registered occupancy only; a same-cycle read does not free a slot.
  assign w_space   = (r_occupancy < c_fifo_size);
  assign w_issue   = w_space & w_valid;
  assign w_read_ok = fifo_read_enable & (r_occupancy != '0);

  // Next occupancy: a write and a valid read in the same cycle cancel out.
  always_comb begin
    w_occ_next = r_occupancy;
    if (w_issue && !w_read_ok) begin
      w_occ_next = r_occupancy + c_occ_one;
    end else if (!w_issue && w_read_ok) begin
      w_occ_next = r_occupancy - c_occ_one;
    end
  end

  // Write path: register the grant, strobe and accepted word; remember the winner.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_grant        <= '0;
      r_write_enable <= 1'b0;
      r_write_data   <= '0;
      r_last_winner  <= c_last_rst;
    end else begin
      r_write_enable <= w_issue;
      if (w_issue) begin
        r_grant       <= NUM_REQ'(1) << w_winner;
        r_write_data  <= w_req_words[w_winner];
        r_last_winner <= w_winner;
      end else begin
        r_grant <= '0;
      end
    end
  end

  // Status path: occupancy and flags decoded from the next-state occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_occupancy  <= '0;
      r_fifo_full  <= 1'b0;
      r_fifo_empty <= 1'b1;
      r_underflow  <= 1'b0;
    end else begin
      r_occupancy  <= w_occ_next;
      r_fifo_full  <= (w_occ_next == c_fifo_size);
      r_fifo_empty <= (w_occ_next == '0);
      r_underflow  <= fifo_read_enable & (r_occupancy == '0);
    end
  end

  assign grant        = r_grant;
  assign write_enable = r_write_enable;
  assign write_data   = r_write_data;
  assign occupancy    = r_occupancy;
  assign fifo_full    = r_fifo_full;
  assign fifo_empty   = r_fifo_empty;
  assign underflow    = r_underflow;

endmodule : fifo_write_arbiter

`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
// ============================================================================
// Module      : tb_fifo_write_arbiter
// Description : Directed self-checking bench for fifo_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fifo_write_arbiter;

  localparam int c_dw = 32;
  localparam int c_nr = 4;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [c_nr-1:0]      req;
  logic [c_nr*c_dw-1:0] req_data;
  logic                 fifo_read_enable;
  logic [c_nr-1:0]      grant;
  logic                 write_enable;
  logic [c_dw-1:0]      write_data;
  logic [3:0]           occupancy;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 underflow;

  logic [c_dw-1:0] words [c_nr];

  int n_checks = 0;
  int n_errors = 0;

  assign req_data = {words[3], words[2], words[1], words[0]};

  fifo_write_arbiter dut (
    .clock            (clock),
    .reset            (reset),
    .req              (req),
    .req_data         (req_data),
    .fifo_read_enable (fifo_read_enable),
    .grant            (grant),
    .write_enable     (write_enable),
    .write_data       (write_data),
    .occupancy        (occupancy),
    .fifo_full        (fifo_full),
    .fifo_empty       (fifo_empty),
    .underflow        (underflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_status(input string tag, input logic [3:0] g, input logic we,
                              input logic [3:0] occ, input logic full, input logic empty);
    check({tag, ".grant"}, 64'(grant), 64'(g));
    check({tag, ".we"},    64'(write_enable), 64'(we));
    check({tag, ".occ"},   64'(occupancy), 64'(occ));
    check({tag, ".full"},  64'(fifo_full), 64'(full));
    check({tag, ".empty"}, 64'(fifo_empty), 64'(empty));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_status(tag, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b1);
    check({tag, ".wdata"}, 64'(write_data), 64'h0);
    check({tag, ".uf"},    64'(underflow), 64'h0);
  endtask

  initial begin
    logic [3:0] exp_g;
    reset            = 1'b1;
    req              = '0;
    fifo_read_enable = 1'b0;
    words[0] = 32'hA0A0_0000;
    words[1] = 32'hB1B1_1111;
    words[2] = 32'hC2C2_2222;
    words[3] = 32'hD3D3_3333;

    // Reset and idle.
    tick();
    tick();
    check_reset_outputs("rst");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_status($sformatf("idle%0d", i), 4'b0000, 1'b0, 4'd0, 1'b0, 1'b1);
    end

    // All requesters active, fill to full in round-robin order.
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_g = 4'b0001 << (k % 4);
      check_status($sformatf("fill%0d", k), exp_g, 1'b1, 4'(k + 1), (k == 7), 1'b0);
      check($sformatf("fill%0d.wdata", k), 64'(write_data), 64'(words[k % 4]));
    end
    tick();
    check_status("full_hold", 4'b0000, 1'b0, 4'd8, 1'b1, 1'b0);
    check("full_hold.wdata", 64'(write_data), 64'(words[3]));

    // Full FIFO, single read frees one slot; grant appears one edge later.
    req              = 4'b0100;
    fifo_read_enable = 1'b1;
    tick();
    check_status("rd_full", 4'b0000, 1'b0, 4'd7, 1'b0, 1'b0);
    fifo_read_enable = 1'b0;
    tick();
    check_status("refill", 4'b0100, 1'b1, 4'd8, 1'b1, 1'b0);
    check("refill.wdata", 64'(write_data), 64'(words[2]));
    req = 4'b0000;

    // Drain to 3, then simultaneous write and read.
    fifo_read_enable = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_status("drain3", 4'b0000, 1'b0, 4'd3, 1'b0, 1'b0);
    words[3] = 32'hCAFE_F00D;
    req      = 4'b1000;
    tick();
    check_status("wr_rd", 4'b1000, 1'b1, 4'd3, 1'b0, 1'b0);
    check("wr_rd.wdata", 64'(write_data), 64'hCAFE_F00D);
    fifo_read_enable = 1'b0;

    // Round-robin wrap: after winner 2, requests {0,2} go to 0.
    req = 4'b0100;
    tick();
    check_status("rr_a", 4'b0100, 1'b1, 4'd4, 1'b0, 1'b0);
    req = 4'b0101;
    tick();
    check_status("rr_wrap", 4'b0001, 1'b1, 4'd5, 1'b0, 1'b0);

    // Mid-operation reset with occupancy 5 and last winner 0.
    req = 4'b0011;
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("arst_now");
    tick();
    check_reset_outputs("arst_edge");
    reset = 1'b0;
    tick();
    check_status("post_rst0", 4'b0001, 1'b1, 4'd1, 1'b0, 1'b0);
    check("post_rst0.wdata", 64'(write_data), 64'(words[0]));
    tick();
    check_status("post_rst1", 4'b0010, 1'b1, 4'd2, 1'b0, 1'b0);
    req = 4'b0000;

    // Drain to empty, then read while empty for underflow.
    fifo_read_enable = 1'b1;
    tick();
    check_status("dr1", 4'b0000, 1'b0, 4'd1, 1'b0, 1'b0);
    check("dr1.uf", 64'(underflow), 64'h0);
    tick();
    check_status("dr0", 4'b0000, 1'b0, 4'd0, 1'b0, 1'b1);
    check("dr0.uf", 64'(underflow), 64'h0);
    tick();
    check_status("uf", 4'b0000, 1'b0, 4'd0, 1'b0, 1'b1);
    check("uf.pulse", 64'(underflow), 64'h1);
    fifo_read_enable = 1'b0;
    tick();
    check("uf.clear", 64'(underflow), 64'h0);
    check("uf.occ", 64'(occupancy), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fifo_write_arbiter

`default_nettype wire
